// File: rtl/cc_types_pkg.sv
// Coherency-controller types: FSM state encoding and the round-robin pick helper.
package cc_types_pkg;

    localparam int MAX_CPU = 8;

    typedef enum logic [2:0] {IDLE, IF, WB, SNOOP, C2C, M2C} cc_state_t;

    // First requester at or after ptr, scanning cyclically over n cores; returns ptr if none.
    function automatic logic [2:0] next_rr(input logic [2:0] ptr,
                                           input logic [MAX_CPU-1:0] req,
                                           input int n);
        logic [2:0] sel;
        logic       found;
        int         cand;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_CPU; k++) begin
            cand = (int'(ptr) + k) % n;
            if (k < n && !found && req[3'(cand)]) begin
                sel   = 3'(cand);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the bus word and the RAM port handshake state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

endpackage

// File: rtl/coherency_controller_n_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr_i, one-hot and encoded.
module rr_arbiter
    import cc_types_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [MAX_CPU-1:0] req_ext;
    logic [2:0]         sel;

    always_comb begin
        req_ext         = '0;
        req_ext[N-1:0]  = req_i;
        sel             = next_rr(3'(ptr_i), req_ext, N);
        idx_o           = IW'(sel);
        valid_o         = |req_i;
        grant_o         = '0;
        if (valid_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/coherency_controller_n.sv
// N-core bus/coherency controller: round-robin access to one RAM port with snoop broadcast.
// Optional CC_PERF_CNT_EN adds C2C/M2C entry counters; otherwise those outputs are tied 0.
module coherency_controller_n
    import cpu_types_pkg::*;
    import cc_types_pkg::*;
#(
    parameter int NCPU  = 2,
    parameter int WORDS = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NCPU-1:0]        iREN,
    input  logic [NCPU-1:0][31:0]  iaddr,
    input  logic [NCPU-1:0]        dREN,
    input  logic [NCPU-1:0]        dWEN,
    input  logic [NCPU-1:0][31:0]  daddr,
    input  logic [NCPU-1:0][31:0]  dstore,
    input  logic [NCPU-1:0]        cctrans,
    input  logic [NCPU-1:0]        ccwrite,
    input  logic [NCPU-1:0]        ccack,
    output logic [NCPU-1:0]        iwait,
    output logic [NCPU-1:0]        dwait,
    output logic [NCPU-1:0][31:0]  iload,
    output logic [NCPU-1:0][31:0]  dload,
    output logic [NCPU-1:0]        ccwait,
    output logic [NCPU-1:0]        ccinv,
    output logic [NCPU-1:0][31:0]  ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output word_t                  ramaddr,
    output word_t                  ramstore,
    input  word_t                  ramload,
    input  ramstate_t              ramstate,
    output word_t                  c2c_cnt,
    output word_t                  m2c_cnt,
    output cc_state_t              dbg_state_o
);

    localparam int IW = $clog2(NCPU);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
    localparam logic [IW-1:0] LAST_CPU  = IW'(NCPU - 1);

    cc_state_t        state_q, state_d;
    logic [IW-1:0]    g_q, g_d, r_q, r_d, ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NCPU-1:0]  req, arb_grant, g_oh, dirty;
    logic [IW-1:0]    arb_idx, r_sel;
    logic             arb_valid, access, acked, snoop_req;

    rr_arbiter #(.N(NCPU), .IW(IW)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            g_q     <= '0;
            r_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            r_q     <= r_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        req       = (cctrans & dREN) | dWEN | iREN;
        access    = (ramstate == ACCESS);
        g_oh      = '0;
        g_oh[g_q] = 1'b1;
        acked     = &(ccack | g_oh);
        dirty     = ccwrite & ~g_oh;
        snoop_req = cctrans[g_q] & dREN[g_q];
        r_sel     = '0;
        for (int j = NCPU - 1; j >= 0; j--) begin
            if (dirty[j]) r_sel = IW'(j);
        end

        state_d     = state_q;
        g_d         = g_q;
        r_d         = r_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    g_d = arb_idx;
                    if (|(arb_grant & cctrans & dREN)) state_d = SNOOP;
                    else if (|(arb_grant & dWEN))      state_d = WB;
                    else                               state_d = IF;
                end
            end
            IF: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr[g_q];
                iload[g_q]   = ramload;
                iwait[g_q]   = !access;
                if (!iREN[g_q]) state_d = IDLE;
            end
            WB: begin
                ramWEN       = dWEN[g_q];
                ramaddr      = daddr[g_q];
                ramstore     = dstore[g_q];
                dwait[g_q]   = !access;
                if (!dWEN[g_q]) state_d = IDLE;
                else if (access) begin
                    if (cnt_q == LAST_WORD) state_d = IDLE;
                    else                    cnt_d   = cnt_q + 1'b1;
                end
            end
            SNOOP: begin
                for (int j = 0; j < NCPU; j++) begin
                    if (IW'(j) != g_q) begin
                        ccwait[j]      = 1'b1;
                        ccsnoopaddr[j] = daddr[g_q];
                        ccinv[j]       = ccwrite[g_q];
                    end
                end
                if (!snoop_req) state_d = IDLE;
                else if (acked) begin
                    // Lowest-index dirty responder supplies the block.
                    cnt_d = '0;
                    if (|dirty) begin
                        state_d = C2C;
                        r_d     = r_sel;
                    end else begin
                        state_d = M2C;
                    end
                end
            end
            C2C: begin
                dload[g_q]       = dstore[r_q];
                ramWEN           = 1'b1;
                ramaddr          = daddr[r_q];
                ramstore         = dstore[r_q];
                dwait[g_q]       = !access;
                dwait[r_q]       = !access;
                ccwait[r_q]      = 1'b1;
                ccsnoopaddr[r_q] = daddr[g_q];
                if (!snoop_req) state_d = IDLE;
                else if (access) begin
                    if (cnt_q == LAST_WORD) state_d = IDLE;
                    else                    cnt_d   = cnt_q + 1'b1;
                end
            end
            M2C: begin
                ramREN     = 1'b1;
                ramaddr    = daddr[g_q];
                dload[g_q] = ramload;
                dwait[g_q] = !access;
                ccwait     = ~g_oh;
                if (!snoop_req) state_d = IDLE;
                else if (access) begin
                    if (cnt_q == LAST_WORD) state_d = IDLE;
                    else                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every exit (normal or aborted) restarts the word count and advances fairness.
        if (state_d == IDLE) cnt_d = '0;
        if (state_q != IDLE && state_d == IDLE) begin
            ptr_d = (g_q == LAST_CPU) ? '0 : g_q + 1'b1;
        end
    end

    assign dbg_state_o = state_q;

`ifdef CC_PERF_CNT_EN
    word_t c2c_q, m2c_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            c2c_q <= '0;
            m2c_q <= '0;
        end else begin
            if (state_q == SNOOP && state_d == C2C) c2c_q <= c2c_q + 32'd1;
            if (state_q == SNOOP && state_d == M2C) m2c_q <= m2c_q + 32'd1;
        end
    end

    assign c2c_cnt = c2c_q;
    assign m2c_cnt = m2c_q;
`else
    assign c2c_cnt = '0;
    assign m2c_cnt = '0;
`endif

endmodule

// File: tb/tb_coherency_controller_n.sv
// Directed bench for coherency_controller_n (NCPU=4, WORDS=2) with a queue-based output scoreboard.
module tb_coherency_controller_n;
    import cpu_types_pkg::*;
    import cc_types_pkg::*;

    localparam int NCPU  = 4;
    localparam int WORDS = 2;
    localparam int EW    = 106;

`ifdef CC_PERF_CNT_EN
    localparam logic [31:0] PERF_ONE = 32'd1;
`else
    localparam logic [31:0] PERF_ONE = 32'd0;
`endif

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [NCPU-1:0]       iREN, dREN, dWEN, cctrans, ccwrite, ccack;
    logic [NCPU-1:0][31:0] iaddr, daddr, dstore;
    logic [NCPU-1:0]       iwait, dwait, ccwait, ccinv;
    logic [NCPU-1:0][31:0] iload, dload, ccsnoopaddr;
    logic                  ramREN, ramWEN;
    word_t                 ramaddr, ramstore, ramload, c2c_cnt, m2c_cnt;
    ramstate_t             ramstate;
    cc_state_t             dbg_state;

    logic [EW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    coherency_controller_n #(.NCPU(NCPU), .WORDS(WORDS)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccack(ccack),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .c2c_cnt(c2c_cnt), .m2c_cnt(m2c_cnt), .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] mk_ev(input logic [3:0] iw, input logic [3:0] dw,
                                            input logic ren, input logic wen,
                                            input logic [31:0] addr, input logic [31:0] st,
                                            input logic [31:0] ld);
        return {iw, dw, ren, wen, addr, st, ld};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".state"},  32'(dbg_state), 32'(IDLE));
        check({tag, ".iwait"},  32'(iwait), 32'hF);
        check({tag, ".dwait"},  32'(dwait), 32'hF);
        check({tag, ".cc"},     32'({ccwait, ccinv}), 32'h0);
        check({tag, ".ramctl"}, 32'({ramREN, ramWEN}), 32'h0);
        check({tag, ".ramaddr"}, ramaddr, 32'h0);
        check({tag, ".ramstore"}, ramstore, 32'h0);
        check({tag, ".loads"},  32'(|{iload, dload, ccsnoopaddr}), 32'h0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] obs, exp;
        logic [31:0]   ld;
        logic          found;
        forever begin
            @(negedge CLK);
            if (~&iwait || ~&dwait) begin
                ld = '0;
                found = 1'b0;
                for (int i = 0; i < NCPU; i++)
                    if (!found && !iwait[i]) begin ld = iload[i]; found = 1'b1; end
                for (int i = 0; i < NCPU; i++)
                    if (!found && !dwait[i]) begin ld = dload[i]; found = 1'b1; end
                obs = mk_ev(iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, ld);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ev: got iw=%b dw=%b ren=%b wen=%b addr=%h st=%h ld=%h, none expected",
                             obs[105:102], obs[101:98], obs[97], obs[96], obs[95:64], obs[63:32], obs[31:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        n_err++;
                        $display("FAIL ev: got iw=%b dw=%b ren=%b wen=%b addr=%h st=%h ld=%h expected iw=%b dw=%b ren=%b wen=%b addr=%h st=%h ld=%h",
                                 obs[105:102], obs[101:98], obs[97], obs[96], obs[95:64], obs[63:32], obs[31:0],
                                 exp[105:102], exp[101:98], exp[97], exp[96], exp[95:64], exp[63:32], exp[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        int c;
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ccack = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        repeat (2) step();
        check_idle("reset");
        check("reset.c2c", c2c_cnt, 32'h0);
        nRST = 1'b1;
        step();

        // Test 1: core1 fetch with two BUSY cycles, then fairness moves to core2.
        iREN[1] = 1'b1; iaddr[1] = 32'h40; ramstate = BUSY; ramload = 32'h1234_5678;
        step();
        check("t1.state", 32'(dbg_state), 32'(IF));
        check("t1.busy_iwait", 32'(iwait), 32'hF);
        step();
        step();
        ramstate = ACCESS; iREN[1] = 1'b0;
        exp_q.push_back(mk_ev(4'b1101, 4'b1111, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1234_5678));
        step();
        ramstate = FREE;
        check_idle("t1.done");
        iREN[0] = 1'b1; iREN[2] = 1'b1; iaddr[0] = 32'h80; iaddr[2] = 32'hC0;
        ramstate = ACCESS; ramload = 32'h2222;
        step();
        iREN[2] = 1'b0;
        exp_q.push_back(mk_ev(4'b1011, 4'b1111, 1'b1, 1'b0, 32'hC0, 32'h0, 32'h2222));
        step();
        ramload = 32'h3333;
        step();
        iREN[0] = 1'b0;
        exp_q.push_back(mk_ev(4'b1110, 4'b1111, 1'b1, 1'b0, 32'h80, 32'h0, 32'h3333));
        step();

        // Test 2: all four cores fetching, grants rotate 0,1,2,3,0.
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        step();
        for (int i = 0; i < NCPU; i++) iaddr[i] = 32'h1000 + 32'(i * 4);
        iREN = '1; ramstate = ACCESS;
        for (int k = 0; k < 5; k++) begin
            c = order[k];
            step();
            iREN[c] = 1'b0;
            ramload = 32'h5000 + 32'(k);
            exp_q.push_back(mk_ev(4'b1111 & ~(4'b0001 << c), 4'b1111, 1'b1, 1'b0,
                                  32'h1000 + 32'(c * 4), 32'h0, 32'h5000 + 32'(k)));
            step();
            iREN[c] = 1'b1;
        end
        iREN = '0; ramstate = FREE;
        step();

        // Test 3: core0 coherent read, core2 holds dirty copy -> C2C of two words.
        cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h100;
        step();
        check("t3.state", 32'(dbg_state), 32'(SNOOP));
        check("t3.ccwait", 32'(ccwait), 32'hE);
        check("t3.ccinv", 32'(ccinv), 32'h0);
        check("t3.snoopaddr2", ccsnoopaddr[2], 32'h100);
        ccack = 4'b1110; ccwrite[2] = 1'b1; daddr[2] = 32'h100; dstore[2] = 32'hAAAA;
        step();
        ramstate = ACCESS; ccack = '0;
        check("t3.c2c_state", 32'(dbg_state), 32'(C2C));
        check("t3.ccwait_r", 32'(ccwait), 32'h4);
        exp_q.push_back(mk_ev(4'b1111, 4'b1010, 1'b0, 1'b1, 32'h100, 32'hAAAA, 32'hAAAA));
        step();
        daddr[2] = 32'h104; dstore[2] = 32'hBBBB;
        exp_q.push_back(mk_ev(4'b1111, 4'b1010, 1'b0, 1'b1, 32'h104, 32'hBBBB, 32'hBBBB));
        step();
        cctrans = '0; dREN = '0; ccwrite = '0; ramstate = FREE;
        check_idle("t3.done");
        check("t3.c2c_cnt", c2c_cnt, PERF_ONE);

        // Test 4: core1 read-exclusive, no dirty copies -> invalidates then M2C.
        cctrans[1] = 1'b1; dREN[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200;
        step();
        check("t4.ccinv", 32'(ccinv), 32'hD);
        check("t4.ccwait", 32'(ccwait), 32'hD);
        check("t4.snoopaddr3", ccsnoopaddr[3], 32'h200);
        check("t4.snoopaddr_g", ccsnoopaddr[1], 32'h0);
        ccack = 4'b0101;
        step();
        check("t4.partial_ack", 32'(dbg_state), 32'(SNOOP));
        ccack = 4'b1101;
        step();
        ramstate = ACCESS; ramload = 32'h1111_2222;
        check("t4.m2c_state", 32'(dbg_state), 32'(M2C));
        check("t4.m2c_ccwait", 32'(ccwait), 32'hD);
        exp_q.push_back(mk_ev(4'b1111, 4'b1101, 1'b1, 1'b0, 32'h200, 32'h0, 32'h1111_2222));
        step();
        daddr[1] = 32'h204; ramload = 32'h3333_4444;
        exp_q.push_back(mk_ev(4'b1111, 4'b1101, 1'b1, 1'b0, 32'h204, 32'h0, 32'h3333_4444));
        step();
        cctrans = '0; dREN = '0; ccwrite = '0; ccack = '0; ramstate = FREE;
        check_idle("t4.done");
        check("t4.m2c_cnt", m2c_cnt, PERF_ONE);

        // Test 5: core3 writeback stalled by ERROR for three cycles.
        dWEN[3] = 1'b1; daddr[3] = 32'h300; dstore[3] = 32'hCAFE_0001; ramstate = ERROR;
        for (int e = 0; e < 3; e++) begin
            step();
            check("t5.err_dwait", 32'(dwait), 32'hF);
        end
        check("t5.state", 32'(dbg_state), 32'(WB));
        step();
        ramstate = ACCESS;
        exp_q.push_back(mk_ev(4'b1111, 4'b0111, 1'b0, 1'b1, 32'h300, 32'hCAFE_0001, 32'h0));
        step();
        daddr[3] = 32'h304; dstore[3] = 32'hCAFE_0002;
        exp_q.push_back(mk_ev(4'b1111, 4'b0111, 1'b0, 1'b1, 32'h304, 32'hCAFE_0002, 32'h0));
        step();
        dWEN = '0; ramstate = FREE;
        check_idle("t5.done");

        // Test 6: reset asserted during the second C2C word.
        cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h400;
        step();
        ccack = 4'b1101; ccwrite[3] = 1'b1; daddr[3] = 32'h400; dstore[3] = 32'h6666_0000;
        step();
        ramstate = ACCESS;
        exp_q.push_back(mk_ev(4'b1111, 4'b0101, 1'b0, 1'b1, 32'h400, 32'h6666_0000, 32'h6666_0000));
        step();
        nRST = 1'b0;
        #1;
        check_idle("t6.rst");
        check("t6.c2c_cnt", c2c_cnt, 32'h0);
        check("t6.m2c_cnt", m2c_cnt, 32'h0);
        cctrans = '0; dREN = '0; ccwrite = '0; ccack = '0;
        iREN = 4'b0101; iaddr[0] = 32'h500; iaddr[2] = 32'h508; ramload = 32'h7777;
        step();
        nRST = 1'b1;
        step();
        iREN[0] = 1'b0;
        check("t6.grant0", 32'(dbg_state), 32'(IF));
        exp_q.push_back(mk_ev(4'b1110, 4'b1111, 1'b1, 1'b0, 32'h500, 32'h0, 32'h7777));
        step();
        iREN = '0; ramstate = FREE;
        step();
        check_idle("end");
        repeat (2) step();

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
